// File: rtl/pmod_input_debounce.sv
// pmod_input_debounce
// Eight-channel (by default) PMOD input conditioner. Each raw pin is
// optionally inverted, passed through a two-flop synchroniser, then
// debounced by a per-channel counter that must see DEBOUNCE_CYCLES
// consecutive mismatching samples before the stable level is updated.
// Registered one-cycle rise/fall pulses accompany every accepted change,
// and a wrapping 8-bit counter totals the rising events of all channels.
//
// Timing summary, input changed and held from before edge k:
//   edge k                      : s1 captures the new level
//   edge k+1                    : s2 captures the new level
//   edges k+2 .. k+1+DEBOUNCE   : mismatch edges, last one updates btn_state
// btn_rise/btn_fall and press_count change on the same edge as btn_state.

module pmod_input_debounce #(
    parameter int NCHAN           = 8,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCHAN-1:0] pmod_in,
    output logic [NCHAN-1:0] btn_state,
    output logic [NCHAN-1:0] btn_rise,
    output logic [NCHAN-1:0] btn_fall,
    output logic [7:0]       press_count
);

    // Counter only ever needs to reach DEBOUNCE_CYCLES-1 before it is cleared.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [NCHAN-1:0] INV_MASK = {NCHAN{ACTIVE_LOW}};

    // Synchroniser stages
    logic [NCHAN-1:0] sync1_q, sync1_d;
    logic [NCHAN-1:0] sync2_q, sync2_d;

    // Debounce state
    logic [CNT_W-1:0] cnt_q [NCHAN];
    logic [CNT_W-1:0] cnt_d [NCHAN];
    logic [NCHAN-1:0] state_q, state_d;

    // Edge pulses and event counter
    logic [NCHAN-1:0] rise_q, rise_d;
    logic [NCHAN-1:0] fall_q, fall_d;
    logic [7:0]       count_q, count_d;
    logic [7:0]       rise_sum;

    // Synchroniser: polarity fix-up sits in front of the first flop only,
    // so nothing but a wire separates the two stages.
    always_comb begin
        sync1_d = pmod_in ^ INV_MASK;
        sync2_d = sync1_q;
    end

    // Per-channel debounce: any sample agreeing with the stable level clears
    // the run; a full run of DEBOUNCE_CYCLES mismatches accepts the new level.
    always_comb begin
        state_d = state_q;
        for (int i = 0; i < NCHAN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == state_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                state_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Edge pulses are derived from the next stable level so they line up
    // with the cycle in which the new btn_state is first visible.
    always_comb begin
        rise_d = state_d & ~state_q;
        fall_d = ~state_d & state_q;
    end

    // Event total: add the number of channels rising this edge, modulo 256.
    always_comb begin
        rise_sum = '0;
        for (int i = 0; i < NCHAN; i++) begin
            rise_sum = rise_sum + 8'(rise_d[i]);
        end
        count_d = count_q + rise_sum;
    end

    // Single register bank; reset clears everything including runs in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < NCHAN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            count_q <= count_d;
            for (int i = 0; i < NCHAN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_state   = state_q;
    assign btn_rise    = rise_q;
    assign btn_fall    = fall_q;
    assign press_count = count_q;

endmodule
